axi_ar_decoder: RTL and testbench

Address-channel decoder that sits directly downstream of the AXI read-address arbiter. It accepts the single arbitrated request (ID already extended with the 4-bit master tag), registers it, decodes the address to one of two slaves or the default (DECERR) slave, and presents it on that slave's address channel. It then holds off further requests until the selected slave completes the burst's last read beat, so that only one read burst is outstanding.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_addr_map.sv | 16 +
 rtl/axi_ar_decoder.sv | 118 +++++++++++
 tb/tb_axi_ar_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, FSM/select encodings and request struct for the address decoders.
package axi_pkg;

    localparam int ID_W    = 4;
    localparam int IDS_W   = 8;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;

    typedef enum logic [1:0] {IDLE, ADDR, BUSY} ar_state_e;

    typedef enum logic [1:0] {SEL_S0, SEL_S1, SEL_SD} sel_e;

    typedef struct packed {
        logic [IDS_W-1:0]   id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_req_t;

endpackage

// File: rtl/axi_addr_map.sv
// axi_addr_map: combinational address-to-slave decode, shared by the AR and AW decoders.
module axi_addr_map
    import axi_pkg::*;
#(
    parameter logic [15:0] S0_BASE = 16'h0000,
    parameter logic [15:0] S1_BASE = 16'h0001
) (
    input  logic [15:0] addr_hi,
    output sel_e        sel
);

    // S0 wins when both bases are configured equal.
    always_comb sel = (addr_hi == S0_BASE) ? SEL_S0 :
                      (addr_hi == S1_BASE) ? SEL_S1 : SEL_SD;

endmodule

// File: rtl/axi_ar_decoder.sv
// axi_ar_decoder: registers the arbitrated AR request, steers VALID to the decoded slave and
// blocks new requests until that slave returns the last read beat.
module axi_ar_decoder
    import axi_pkg::*;
#(
    parameter logic [15:0] S0_BASE = 16'h0000,
    parameter logic [15:0] S1_BASE = 16'h0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDS_W-1:0]   ID_M,
    input  logic [ADDR_W-1:0]  ADDR_M,
    input  logic [LEN_W-1:0]   LEN_M,
    input  logic [SIZE_W-1:0]  SIZE_M,
    input  logic [BURST_W-1:0] BURST_M,
    input  logic               VALID_M,
    output logic               READY_M,
    output logic [IDS_W-1:0]   ID_S0,
    output logic [ADDR_W-1:0]  ADDR_S0,
    output logic [LEN_W-1:0]   LEN_S0,
    output logic [SIZE_W-1:0]  SIZE_S0,
    output logic [BURST_W-1:0] BURST_S0,
    output logic               VALID_S0,
    input  logic               READY_S0,
    input  logic               RVALID_S0,
    input  logic               RREADY_S0,
    input  logic               RLAST_S0,
    output logic [IDS_W-1:0]   ID_S1,
    output logic [ADDR_W-1:0]  ADDR_S1,
    output logic [LEN_W-1:0]   LEN_S1,
    output logic [SIZE_W-1:0]  SIZE_S1,
    output logic [BURST_W-1:0] BURST_S1,
    output logic               VALID_S1,
    input  logic               READY_S1,
    input  logic               RVALID_S1,
    input  logic               RREADY_S1,
    input  logic               RLAST_S1,
    output logic [IDS_W-1:0]   ID_SD,
    output logic [ADDR_W-1:0]  ADDR_SD,
    output logic [LEN_W-1:0]   LEN_SD,
    output logic [SIZE_W-1:0]  SIZE_SD,
    output logic [BURST_W-1:0] BURST_SD,
    output logic               VALID_SD,
    input  logic               READY_SD,
    input  logic               RVALID_SD,
    input  logic               RREADY_SD,
    input  logic               RLAST_SD
);

    ar_state_e state_q, state_d;
    sel_e      sel_q, sel_d, dec_sel;
    ar_req_t   req_q, req_d;
    logic      sel_ready, sel_last;

    axi_addr_map #(
        .S0_BASE(S0_BASE),
        .S1_BASE(S1_BASE)
    ) u_addr_map (
        .addr_hi(ADDR_M[31:16]),
        .sel    (dec_sel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_SD;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
        end
    end

    // Only the selected slave's handshakes are observed; the others are ignored.
    always_comb begin
        sel_ready = (sel_q == SEL_S0) ? READY_S0 :
                    (sel_q == SEL_S1) ? READY_S1 : READY_SD;
        sel_last  = (sel_q == SEL_S0) ? (RVALID_S0 & RREADY_S0 & RLAST_S0) :
                    (sel_q == SEL_S1) ? (RVALID_S1 & RREADY_S1 & RLAST_S1) :
                                        (RVALID_SD & RREADY_SD & RLAST_SD);
        state_d   = state_q;
        sel_d     = sel_q;
        req_d     = req_q;
        case (state_q)
            IDLE: if (VALID_M) begin
                state_d = ADDR;
                sel_d   = dec_sel;
                req_d   = '{id: ID_M, addr: ADDR_M, len: LEN_M, size: SIZE_M, burst: BURST_M};
            end
            ADDR:    if (sel_ready) state_d = BUSY;
            BUSY:    if (sel_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign READY_M  = (state_q == IDLE);
    assign VALID_S0 = (state_q == ADDR) && (sel_q == SEL_S0);
    assign VALID_S1 = (state_q == ADDR) && (sel_q == SEL_S1);
    assign VALID_SD = (state_q == ADDR) && (sel_q == SEL_SD);

    assign ID_S0    = req_q.id;
    assign ADDR_S0  = req_q.addr;
    assign LEN_S0   = req_q.len;
    assign SIZE_S0  = req_q.size;
    assign BURST_S0 = req_q.burst;
    assign ID_S1    = req_q.id;
    assign ADDR_S1  = req_q.addr;
    assign LEN_S1   = req_q.len;
    assign SIZE_S1  = req_q.size;
    assign BURST_S1 = req_q.burst;
    assign ID_SD    = req_q.id;
    assign ADDR_SD  = req_q.addr;
    assign LEN_SD   = req_q.len;
    assign SIZE_SD  = req_q.size;
    assign BURST_SD = req_q.burst;

endmodule

// File: tb/tb_axi_ar_decoder.sv
// tb_axi_ar_decoder: randomized AR traffic with a queue scoreboard checked on every slave AR handshake.
module tb_axi_ar_decoder;

    localparam logic [15:0] S0_BASE = 16'h0000;
    localparam logic [15:0] S1_BASE = 16'h0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ID_M;
    logic [31:0] ADDR_M;
    logic [3:0]  LEN_M;
    logic [2:0]  SIZE_M;
    logic [1:0]  BURST_M;
    logic        VALID_M;
    logic        READY_M;

    logic [7:0]  id_s    [3];
    logic [31:0] addr_s  [3];
    logic [3:0]  len_s   [3];
    logic [2:0]  size_s  [3];
    logic [1:0]  burst_s [3];
    logic        valid_s [3];
    logic        s_ready [3];
    logic        s_rvalid[3];
    logic        s_rready[3];
    logic        s_rlast [3];

    typedef struct {
        int          tgt;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    axi_ar_decoder #(.S0_BASE(S0_BASE), .S1_BASE(S1_BASE)) dut (
        .clk(clk), .rst(rst_n),
        .ID_M(ID_M), .ADDR_M(ADDR_M), .LEN_M(LEN_M), .SIZE_M(SIZE_M), .BURST_M(BURST_M),
        .VALID_M(VALID_M), .READY_M(READY_M),
        .ID_S0(id_s[0]), .ADDR_S0(addr_s[0]), .LEN_S0(len_s[0]), .SIZE_S0(size_s[0]),
        .BURST_S0(burst_s[0]), .VALID_S0(valid_s[0]), .READY_S0(s_ready[0]),
        .RVALID_S0(s_rvalid[0]), .RREADY_S0(s_rready[0]), .RLAST_S0(s_rlast[0]),
        .ID_S1(id_s[1]), .ADDR_S1(addr_s[1]), .LEN_S1(len_s[1]), .SIZE_S1(size_s[1]),
        .BURST_S1(burst_s[1]), .VALID_S1(valid_s[1]), .READY_S1(s_ready[1]),
        .RVALID_S1(s_rvalid[1]), .RREADY_S1(s_rready[1]), .RLAST_S1(s_rlast[1]),
        .ID_SD(id_s[2]), .ADDR_SD(addr_s[2]), .LEN_SD(len_s[2]), .SIZE_SD(size_s[2]),
        .BURST_SD(burst_s[2]), .VALID_SD(valid_s[2]), .READY_SD(s_ready[2]),
        .RVALID_SD(s_rvalid[2]), .RREADY_SD(s_rready[2]), .RLAST_SD(s_rlast[2])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_tgt(input logic [31:0] a);
        logic [15:0] hi;
        hi = a[31:16];
        if (hi == S0_BASE) return 0;
        if (hi == S1_BASE) return 1;
        return 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_r();
        for (int k = 0; k < 3; k++) begin
            s_rvalid[k] = 1'b0;
            s_rready[k] = 1'b0;
            s_rlast[k]  = 1'b0;
        end
    endtask

    // Monitor: every AR handshake on a slave port pops one expected request.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (valid_s[k] && s_ready[k]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_ar", 64'(k), 64'hff);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("route", 64'(k), 64'(e.tgt));
                        chk("valid_count", 64'(int'(valid_s[0]) + int'(valid_s[1]) + int'(valid_s[2])), 1);
                        for (int j = 0; j < 3; j++) begin
                            chk("ar_id", id_s[j], e.id);
                            chk("ar_addr", addr_s[j], e.addr);
                            chk("ar_len", len_s[j], e.len);
                            chk("ar_size", size_s[j], e.size);
                            chk("ar_burst", burst_s[j], e.burst);
                        end
                    end
                end
            end
        end
    end

    task automatic run_req(input logic [31:0] a, input logic [7:0] id, input logic [3:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input int wait_c,
                           input bit early, input bit noise);
        int   t;
        int   o;
        exp_t e;
        t = ref_tgt(a);
        ID_M = id; ADDR_M = a; LEN_M = len; SIZE_M = sz; BURST_M = bu; VALID_M = 1'b1;
        @(negedge clk);
        chk("ready_m_idle", READY_M, 1);
        e = '{t, id, a, len, sz, bu};
        q.push_back(e);
        step();
        VALID_M = 1'b0;
        @(negedge clk);
        chk("latency_valid", valid_s[t], 1);
        chk("ready_m_addr", READY_M, 0);
        for (int i = 0; i < wait_c; i++) begin
            VALID_M = 1'b1; ADDR_M = ~a; ID_M = ~id;
            step();
            @(negedge clk);
            chk("bp_valid", valid_s[t], 1);
            chk("bp_addr", addr_s[t], a);
            chk("bp_id", id_s[t], id);
            chk("bp_ready_m", READY_M, 0);
        end
        step();
        VALID_M = 1'b0;
        s_ready[t] = 1'b1;
        if (early) begin
            s_rvalid[t] = 1'b1; s_rready[t] = 1'b1; s_rlast[t] = 1'b1;
        end
        for (int b = 0; b <= int'(len); b++) begin
            if (noise && $urandom_range(1) == 1) begin
                step();
                s_ready[t] = 1'b0;
                clear_r();
                o = (t + 1 + int'($urandom_range(1))) % 3;
                s_rvalid[o] = 1'b1; s_rready[o] = 1'b1; s_rlast[o] = 1'b1;
                s_rvalid[t] = 1'b1; s_rlast[t] = 1'b1;
                @(negedge clk);
                chk("busy_ready_m", READY_M, 0);
            end
            step();
            s_ready[t] = 1'b0;
            clear_r();
            s_rvalid[t] = 1'b1; s_rready[t] = 1'b1; s_rlast[t] = (b == int'(len));
            @(negedge clk);
            chk("busy_ready_m", READY_M, 0);
            chk("busy_valid", valid_s[t], 0);
        end
        step();
        clear_r();
        @(negedge clk);
        chk("done_ready_m", READY_M, 1);
        chk("done_valid", valid_s[t], 0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] hi;
        rst_n = 1'b0;
        VALID_M = 1'b0; ID_M = '0; ADDR_M = '0; LEN_M = '0; SIZE_M = '0; BURST_M = '0;
        for (int k = 0; k < 3; k++) s_ready[k] = 1'b0;
        clear_r();
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_m", READY_M, 1);
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", valid_s[k], 0);
            chk("rst_payload", {id_s[k], addr_s[k], len_s[k], size_s[k], burst_s[k]}, 0);
        end
        step();

        run_req(32'h0000_0040, 8'h13, 4'd3, 3'd2, 2'd1, 0, 1'b0, 1'b0);
        run_req(32'h0001_0008, 8'h25, 4'd0, 3'd1, 2'd1, 0, 1'b0, 1'b0);
        run_req(32'h0002_0000, 8'h3a, 4'd1, 3'd3, 2'd2, 0, 1'b0, 1'b0);
        run_req(32'h0001_1234, 8'h47, 4'd2, 3'd2, 2'd0, 5, 1'b0, 1'b0);
        run_req(32'h0000_0100, 8'h51, 4'd3, 3'd2, 2'd1, 0, 1'b0, 1'b1);
        run_req(32'h0000_0200, 8'h62, 4'd0, 3'd0, 2'd1, 0, 1'b1, 1'b0);
        run_req(32'h0000_0000, 8'hff, 4'd15, 3'd7, 2'd3, 1, 1'b0, 1'b0);
        run_req(32'hffff_ffff, 8'h00, 4'd0, 3'd0, 2'd0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(3))
                0: hi = S0_BASE;
                1: hi = S1_BASE;
                2: hi = 16'h0002;
                default: hi = 16'($urandom);
            endcase
            a = {hi, 16'($urandom)};
            run_req(a, 8'($urandom), 4'($urandom), 3'($urandom), 2'($urandom),
                    int'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Reset while S0 is being offered and not yet accepted.
        ID_M = 8'h99; ADDR_M = 32'h0000_0abc; LEN_M = 4'd2; VALID_M = 1'b1;
        step();
        VALID_M = 1'b0;
        @(negedge clk);
        chk("mid_valid_s0", valid_s[0], 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_s0", valid_s[0], 0);
        chk("mid_rst_ready_m", READY_M, 1);
        chk("mid_rst_addr", addr_s[0], 0);
        chk("mid_rst_id", id_s[0], 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_m", READY_M, 1);
        step();
        run_req(32'h0001_0010, 8'h77, 4'd1, 3'd2, 2'd1, 0, 1'b0, 1'b0);

        chk("queue_empty", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
